// File: rtl/pwm_pkg.sv
// Shared constants, channel-mode encoding and small helpers for the PWM peripheral.
package pwm_pkg;

  localparam int PWM_CNT_W = 8;
  localparam int PWM_CH    = 16;

  localparam logic [PWM_CNT_W-1:0] DUTY_OFF  = 8'h00;
  localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;

  typedef enum logic [1:0] {
    CH_OFF,
    CH_STATIC,
    CH_PWM
  } ch_mode_e;

  // Output enable dominates: a disabled channel is low whatever its PWM select says.
  function automatic ch_mode_e ch_mode(input logic en_out, input logic en_pwm);
    ch_mode_e mode;
    if (!en_out)     mode = CH_OFF;
    else if (en_pwm) mode = CH_PWM;
    else             mode = CH_STATIC;
    return mode;
  endfunction

  // Full-scale duty is held solidly high instead of dropping low at count 255.
  function automatic logic pwm_level(input logic [PWM_CNT_W-1:0] cnt,
                                     input logic [PWM_CNT_W-1:0] duty);
    logic level;
    if (duty == DUTY_OFF)       level = 1'b0;
    else if (duty == DUTY_FULL) level = 1'b1;
    else                        level = (cnt < duty);
    return level;
  endfunction

  function automatic logic ch_drive(input ch_mode_e mode, input logic level);
    logic drive;
    case (mode)
      CH_OFF:    drive = 1'b0;
      CH_STATIC: drive = 1'b1;
      CH_PWM:    drive = level;
      default:   drive = 1'b0;
    endcase
    return drive;
  endfunction

endpackage

// File: rtl/pwm_peripheral_if.sv
// Configuration inputs from the register block and the channel outputs of the PWM peripheral.
interface pwm_peripheral_if;
  import pwm_pkg::*;

  logic [7:0]        en_reg_out_7_0;
  logic [7:0]        en_reg_out_15_8;
  logic [7:0]        en_reg_pwm_7_0;
  logic [7:0]        en_reg_pwm_15_8;
  logic [7:0]        pwm_duty_cycle;
  logic [PWM_CH-1:0] out;
  logic              period_start;

  modport master (
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
    input  out, period_start
  );

  modport slave (
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
    output out, period_start
  );
endinterface

// File: rtl/pwm_prescaler.sv
// Clock-enable generator: tick on the last of every CLK_DIV clocks, prescale_zero on the first.
module pwm_prescaler #(
  parameter int CLK_DIV = 3000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick,
  output logic prescale_zero
);

  generate
    if (CLK_DIV <= 1) begin : g_div1
      // Every clock is both first and last of its step; no counter needed.
      assign tick          = 1'b1;
      assign prescale_zero = 1'b1;
    end else begin : g_divn
      localparam int CNT_W = $clog2(CLK_DIV);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
      localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

      logic [CNT_W-1:0] prescale_cnt_reg;
      logic [CNT_W-1:0] prescale_cnt_next;

      assign tick          = (prescale_cnt_reg == CNT_LAST);
      assign prescale_zero = (prescale_cnt_reg == '0);

      always_comb begin
        prescale_cnt_next = prescale_cnt_reg + CNT_ONE;
        if (tick) prescale_cnt_next = '0;
      end

      always_ff @(posedge clk) begin
        if (!rst_n) prescale_cnt_reg <= '0;
        else        prescale_cnt_reg <= prescale_cnt_next;
      end
    end
  endgenerate

endmodule

// File: rtl/pwm_peripheral.sv
// 16-channel PWM output stage (off / static high / PWM per channel) with a shared 8-bit counter.
// Optional macro PWM_SHADOW_UPDATE_EN defers duty changes to the next period start.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = 3000
) (
  input  logic              clk,
  input  logic              rst_n,
  pwm_peripheral_if.slave   bus
);

  logic                 tick;
  logic                 prescale_zero;
  logic [PWM_CNT_W-1:0] pwm_cnt_reg;
  logic [PWM_CNT_W-1:0] pwm_cnt_next;
  logic                 period_cond;
  logic [PWM_CNT_W-1:0] duty_eff;
  logic                 pwm_level_c;
  logic [PWM_CH-1:0]    en_out;
  logic [PWM_CH-1:0]    en_pwm;
  logic [PWM_CH-1:0]    out_reg;
  logic [PWM_CH-1:0]    out_next;
  logic                 period_start_reg;

  pwm_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
    .clk           (clk),
    .rst_n         (rst_n),
    .tick          (tick),
    .prescale_zero (prescale_zero)
  );

  assign pwm_cnt_next = tick ? pwm_cnt_reg + PWM_CNT_W'(1) : pwm_cnt_reg;
  assign period_cond  = prescale_zero && (pwm_cnt_reg == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) pwm_cnt_reg <= '0;
    else        pwm_cnt_reg <= pwm_cnt_next;
  end

`ifdef PWM_SHADOW_UPDATE_EN
  logic [PWM_CNT_W-1:0] duty_shadow_reg;

  always_ff @(posedge clk) begin
    if (!rst_n)           duty_shadow_reg <= '0;
    else if (period_cond) duty_shadow_reg <= bus.pwm_duty_cycle;
  end

  // Bypass on the first clock so the freshly latched value already governs it.
  assign duty_eff = period_cond ? bus.pwm_duty_cycle : duty_shadow_reg;
`else
  assign duty_eff = bus.pwm_duty_cycle;
`endif

  assign pwm_level_c = pwm_level(pwm_cnt_reg, duty_eff);
  assign en_out      = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
  assign en_pwm      = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};

  generate
    for (genvar gi = 0; gi < PWM_CH; gi++) begin : g_ch
      assign out_next[gi] = ch_drive(ch_mode(en_out[gi], en_pwm[gi]), pwm_level_c);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_reg          <= '0;
      period_start_reg <= 1'b0;
    end else begin
      out_reg          <= out_next;
      period_start_reg <= period_cond;
    end
  end

  assign bus.out          = out_reg;
  assign bus.period_start = period_start_reg;

endmodule
